// File: rtl/mem_pkg.sv
// Shared encodings for the pipeline memory stage.
// Size codes, writeback select and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Store lane/byte-enable formatting, load extraction
// and misalignment detection; purely combinational.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic is_b;
  logic is_h;
  logic sext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign sext = (funct3 == F3_B) || (funct3 == F3_H);

  assign sel_byte = rdata[{offset, 3'b000} +: 8];
  assign sel_half = rdata[{offset[1], 4'b0000} +: 16];

  // Size decode: lanes, enables, extraction and alignment check.
  always_comb begin
    wdata      = store_data;
    be         = 4'b1111;
    load_data  = rdata;
    misaligned = 1'b0;
    unique case (1'b1)
      is_b: begin
        wdata     = {4{store_data[7:0]}};
        be        = is_store ? (4'b0001 << offset) : 4'b1111;
        load_data = {{24{sext & sel_byte[7]}}, sel_byte};
      end
      is_h: begin
        wdata      = {2{store_data[15:0]}};
        be         = is_store ? (4'b0011 << {offset[1], 1'b0})
                              : 4'b1111;
        load_data  = {{16{sext & sel_half[15]}}, sel_half};
        misaligned = offset[0];
      end
      default: begin
        misaligned = (funct3 == F3_W) && (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: dmem handshake, stall, timeout
// and the MEM/WB register feeding writeback.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  input  logic [4:0]  ex_mem_rd_addr,
  input  logic        ex_mem_reg_write_en,
  input  logic [1:0]  ex_mem_mem_to_reg,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] mem_wb_dmem_data_out,
  output logic [31:0] mem_wb_alu_result,
  output logic [4:0]  mem_wb_rd_addr,
  output logic        mem_wb_reg_write_en,
  output logic [1:0]  mem_wb_mem_to_reg
);

  localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_TIMEOUT - 1);

  mem_state_t    state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;

  logic        access;
  logic        misaligned;
  logic        abandon;
  logic        complete;
  logic [31:0] load_data;

  logic [31:0] data_nx;
  logic [31:0] alu_nx;
  logic [4:0]  rd_nx;
  logic        rwe_nx;
  logic [1:0]  mtr_nx;

  load_store_align u_align (
    .funct3     (ex_mem_funct3),
    .offset     (ex_mem_alu_result[1:0]),
    .is_store   (ex_mem_mem_write),
    .store_data (ex_mem_rs2_data),
    .rdata      (dmem_rdata),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign access = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

  // Reset withdraws the request immediately, even mid-wait.
  assign dmem_req  = rst_n & access & ~misaligned;
  assign dmem_we   = ex_mem_mem_write;
  assign dmem_addr = {ex_mem_alu_result[31:2], 2'b00};

  assign abandon = (DMEM_TIMEOUT != 0) & (state == ST_WAIT)
                 & dmem_req & ~dmem_ready & (wait_cnt == CNT_LAST);
  assign complete  = dmem_req & dmem_ready;
  assign mem_stall = dmem_req & ~dmem_ready & ~abandon;
  assign mem_fault = rst_n & ((access & misaligned) | abandon);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Next state: wait while request is outstanding, bounded.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (dmem_req & ~dmem_ready) begin
          state_nx    = ST_WAIT;
          wait_cnt_nx = '0;
        end
      end
      ST_WAIT: begin
        if (~dmem_req | dmem_ready | abandon) begin
          state_nx    = ST_IDLE;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, kill on fault.
  always_comb begin
    data_nx = '0;
    alu_nx  = '0;
    rd_nx   = '0;
    rwe_nx  = 1'b0;
    mtr_nx  = MTR_ALU;
    if (!mem_stall && ex_mem_valid) begin
      alu_nx  = ex_mem_alu_result;
      rd_nx   = ex_mem_rd_addr;
      mtr_nx  = ex_mem_mem_to_reg;
      rwe_nx  = ex_mem_reg_write_en & ~mem_fault;
      if (ex_mem_mem_read & complete) begin
        data_nx = load_data;
      end
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_dmem_data_out <= '0;
      mem_wb_alu_result    <= '0;
      mem_wb_rd_addr       <= '0;
      mem_wb_reg_write_en  <= 1'b0;
      mem_wb_mem_to_reg    <= MTR_ALU;
    end else begin
      mem_wb_dmem_data_out <= data_nx;
      mem_wb_alu_result    <= alu_nx;
      mem_wb_rd_addr       <= rd_nx;
      mem_wb_reg_write_en  <= rwe_nx;
      mem_wb_mem_to_reg    <= mtr_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: zero-wait vector table plus
// wait-state, timeout, ready/timeout collision and reset sequences.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_mem_valid = 1'b0;
  logic [31:0] ex_mem_alu_result = '0;
  logic [31:0] ex_mem_rs2_data = '0;
  logic [4:0]  ex_mem_rd_addr = '0;
  logic        ex_mem_reg_write_en = 1'b0;
  logic [1:0]  ex_mem_mem_to_reg = '0;
  logic        ex_mem_mem_read = 1'b0;
  logic        ex_mem_mem_write = 1'b0;
  logic [2:0]  ex_mem_funct3 = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic        mem_fault;
  logic [31:0] mem_wb_dmem_data_out;
  logic [31:0] mem_wb_alu_result;
  logic [4:0]  mem_wb_rd_addr;
  logic        mem_wb_reg_write_en;
  logic [1:0]  mem_wb_mem_to_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_mem_valid         (ex_mem_valid),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_rs2_data      (ex_mem_rs2_data),
    .ex_mem_rd_addr       (ex_mem_rd_addr),
    .ex_mem_reg_write_en  (ex_mem_reg_write_en),
    .ex_mem_mem_to_reg    (ex_mem_mem_to_reg),
    .ex_mem_mem_read      (ex_mem_mem_read),
    .ex_mem_mem_write     (ex_mem_mem_write),
    .ex_mem_funct3        (ex_mem_funct3),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_be              (dmem_be),
    .dmem_ready           (dmem_ready),
    .dmem_rdata           (dmem_rdata),
    .mem_stall            (mem_stall),
    .mem_fault            (mem_fault),
    .mem_wb_dmem_data_out (mem_wb_dmem_data_out),
    .mem_wb_alu_result    (mem_wb_alu_result),
    .mem_wb_rd_addr       (mem_wb_rd_addr),
    .mem_wb_reg_write_en  (mem_wb_reg_write_en),
    .mem_wb_mem_to_reg    (mem_wb_mem_to_reg)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        rwe;
    logic        valid;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic [31:0] e_data;
    logic        e_rwe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic w,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic rwe);
    ex_mem_valid        = v;
    ex_mem_mem_read     = r;
    ex_mem_mem_write    = w;
    ex_mem_funct3       = f3;
    ex_mem_alu_result   = a;
    ex_mem_rs2_data     = sd;
    ex_mem_reg_write_en = rwe;
    ex_mem_rd_addr      = 5'd7;
    ex_mem_mem_to_reg   = r ? MTR_MEM : MTR_ALU;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    dmem_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"sw",    0,1,F3_W, 32'h100,32'hDEADBEEF,32'h0,       0,1,
                 1,4'b1111,32'hDEADBEEF,0,32'h0,0};
    vecs[1]  = '{"lhu",   1,0,F3_HU,32'h102,32'h0,       32'h80011234,1,1,
                 1,4'b1111,32'h0,0,32'h00008001,1};
    vecs[2]  = '{"sh",    0,1,F3_H, 32'h102,32'h0000ABCD,32'h0,       0,1,
                 1,4'b1100,32'hABCDABCD,0,32'h0,0};
    vecs[3]  = '{"lw_mis",1,0,F3_W, 32'h101,32'h0,       32'h12345678,1,1,
                 0,4'b1111,32'h0,1,32'h0,0};
    vecs[4]  = '{"sb",    0,1,F3_B, 32'h101,32'h12345678,32'h0,       0,1,
                 1,4'b0010,32'h78787878,0,32'h0,0};
    vecs[5]  = '{"lh",    1,0,F3_H, 32'h100,32'h0,       32'h0000F00D,1,1,
                 1,4'b1111,32'h0,0,32'hFFFFF00D,1};
    vecs[6]  = '{"lbu",   1,0,F3_BU,32'h101,32'h0,       32'h0000A500,1,1,
                 1,4'b1111,32'h0,0,32'h000000A5,1};
    vecs[7]  = '{"lw",    1,0,F3_W, 32'h104,32'h0,       32'hCAFEBABE,1,1,
                 1,4'b1111,32'h0,0,32'hCAFEBABE,1};
    vecs[8]  = '{"alu",   0,0,F3_W, 32'h55, 32'h0,       32'hFFFFFFFF,1,1,
                 0,4'b1111,32'h0,0,32'h0,1};
    vecs[9]  = '{"bubble",1,0,F3_W, 32'h200,32'h0,       32'h11111111,1,0,
                 0,4'b1111,32'h0,0,32'h0,0};
    vecs[10] = '{"sh_mis",0,1,F3_H, 32'h103,32'h0000ABCD,32'h0,       0,1,
                 0,4'b1100,32'hABCDABCD,1,32'h0,0};

    #2;
    chk("rst_req",   {31'b0, dmem_req}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_fault", {31'b0, mem_fault}, 32'h0);
    chk("rst_rwe",   {31'b0, mem_wb_reg_write_en}, 32'h0);
    chk("rst_data",  mem_wb_dmem_data_out, 32'h0);
    chk("rst_alu",   mem_wb_alu_result, 32'h0);
    #11 rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].f3,
            vecs[i].addr, vecs[i].sdata, vecs[i].rwe);
      dmem_rdata = vecs[i].rdata;
      dmem_ready = 1'b1;
      #3;
      chk({vecs[i].name, "_req"}, {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      chk({vecs[i].name, "_stall"}, {31'b0, mem_stall}, 32'h0);
      chk({vecs[i].name, "_fault"}, {31'b0, mem_fault},
          {31'b0, vecs[i].e_fault});
      if (vecs[i].e_req) begin
        chk({vecs[i].name, "_addr"}, dmem_addr,
            {vecs[i].addr[31:2], 2'b00});
        chk({vecs[i].name, "_be"}, {28'b0, dmem_be}, {28'b0, vecs[i].e_be});
        chk({vecs[i].name, "_we"}, {31'b0, dmem_we}, {31'b0, vecs[i].wr});
        if (vecs[i].wr)
          chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].e_wdata);
      end
      step();
      chk({vecs[i].name, "_wbdata"}, mem_wb_dmem_data_out, vecs[i].e_data);
      chk({vecs[i].name, "_wbrwe"}, {31'b0, mem_wb_reg_write_en},
          {31'b0, vecs[i].e_rwe});
      if (vecs[i].valid)
        chk({vecs[i].name, "_wbalu"}, mem_wb_alu_result, vecs[i].addr);
    end

    // LB with three wait cycles: three stalls, three bubbles.
    drive(1'b1, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 1'b1);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("lbw_stall", {31'b0, mem_stall}, 32'h1);
      chk("lbw_req",   {31'b0, dmem_req}, 32'h1);
      chk("lbw_fault", {31'b0, mem_fault}, 32'h0);
      step();
      chk("lbw_bubble", {31'b0, mem_wb_reg_write_en}, 32'h0);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF0000;
    #3;
    chk("lbw_done_stall", {31'b0, mem_stall}, 32'h0);
    step();
    chk("lbw_data", mem_wb_dmem_data_out, 32'hFFFFFF80);
    chk("lbw_rwe",  {31'b0, mem_wb_reg_write_en}, 32'h1);
    idle_in();
    step();

    // Timeout: four stall cycles, then abandon with fault.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h200, 32'h0, 1'b1);
    dmem_rdata = 32'h5A5A5A5A;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("to_stall", {31'b0, mem_stall}, 32'h1);
      chk("to_nofault", {31'b0, mem_fault}, 32'h0);
      step();
    end
    #3;
    chk("to_end_stall", {31'b0, mem_stall}, 32'h0);
    chk("to_fault", {31'b0, mem_fault}, 32'h1);
    step();
    chk("to_data", mem_wb_dmem_data_out, 32'h0);
    chk("to_rwe",  {31'b0, mem_wb_reg_write_en}, 32'h0);
    idle_in();
    #3;
    chk("to_fault_gone", {31'b0, mem_fault}, 32'h0);
    step();

    // Ready on the timeout cycle wins over the abandon.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h204, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("col_stall", {31'b0, mem_stall}, 32'h1);
      step();
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h13579BDF;
    #3;
    chk("col_fault", {31'b0, mem_fault}, 32'h0);
    chk("col_stall_end", {31'b0, mem_stall}, 32'h0);
    step();
    chk("col_data", mem_wb_dmem_data_out, 32'h13579BDF);
    chk("col_rwe",  {31'b0, mem_wb_reg_write_en}, 32'h1);
    idle_in();
    step();

    // Reset asserted in the middle of a wait.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h300, 32'h0, 1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_req",   {31'b0, dmem_req}, 32'h0);
    chk("rw_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_fault", {31'b0, mem_fault}, 32'h0);
    chk("rw_alu",   mem_wb_alu_result, 32'h0);
    chk("rw_rwe",   {31'b0, mem_wb_reg_write_en}, 32'h0);
    chk("rw_rd",    {27'b0, mem_wb_rd_addr}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h308, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h2468ACE0;
    #3;
    chk("after_rst_stall", {31'b0, mem_stall}, 32'h0);
    step();
    chk("after_rst_data", mem_wb_dmem_data_out, 32'h2468ACE0);
    chk("after_rst_rwe",  {31'b0, mem_wb_reg_write_en}, 32'h1);
    idle_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage between the EX/MEM register and the writeback stage. Issues load/store requests to data memory over a ready-based handshake, formats store byte lanes and load sign/zero extension, stalls the pipeline while memory is busy, and owns the MEM/WB pipeline register that feeds writeback. A wait counter bounds every access; on overrun the access is abandoned and flagged.

## Interface
- DMEM_TIMEOUT, 16: maximum wait cycles after the issue cycle before abandoning; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_mem_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- ex_mem_alu_result  in  32  effective address or ALU result.
- ex_mem_rs2_data  in  32  store data.
- ex_mem_rd_addr  in  5  destination register.
- ex_mem_reg_write_en  in  1  register write request.
- ex_mem_mem_to_reg  in  2  writeback select, passed through (01 = load data, 00 = ALU).
- ex_mem_mem_read / ex_mem_mem_write  in  1 each  load / store.
- ex_mem_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  access request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read word, valid with dmem_ready.
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- mem_fault  out  1  one-cycle pulse: misaligned access or timeout.
- mem_wb_dmem_data_out, mem_wb_alu_result  out  32 each  MEM/WB register.
- mem_wb_rd_addr  out  5; mem_wb_reg_write_en  out  1; mem_wb_mem_to_reg  out  2  MEM/WB register.

## Operation
- Access = ex_mem_valid & (mem_read | mem_write). Misaligned = H/HU with addr[0]=1, or W with addr[1:0]≠0.
- FSM states: IDLE, WAIT.
  - IDLE: access & aligned → dmem_req=1 combinationally. If dmem_ready is high the same cycle, complete and stay IDLE; otherwise go to WAIT with wait_cnt=0.
  - WAIT: dmem_req held with identical addr, we, be and wdata. On dmem_ready, complete and return to IDLE. Else if DMEM_TIMEOUT≠0 and wait_cnt==DMEM_TIMEOUT-1, abandon, pulse mem_fault and return to IDLE. Else increment wait_cnt.
- Misaligned access: no dmem_req, no stall, mem_fault pulses, and the instruction retires with reg_write_en forced to 0.
- mem_stall = dmem_req & ~dmem_ready & ~abandon.
- Store lanes: B replicates byte 4× with be=0001<<addr[1:0]; H replicates halfword 2× with be=0011<<{addr[1],0}; W uses be=1111. Loads drive be=1111.
- Load extract: select the byte/halfword by addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU); W passes through.
- MEM/WB update on every cycle that mem_stall=0. While stalled, MEM/WB loads a bubble (reg_write_en=0, other fields 0). Abandoned loads write dmem_data_out=0 and reg_write_en=0.
- Non-access instructions pass through in one cycle with dmem_data_out=0.

## Timing
- Reset (async, immediate): state IDLE, wait_cnt 0, all mem_wb_* outputs 0, dmem_req 0, mem_stall 0, mem_fault 0.
- Latency is 1 cycle EX/MEM → MEM/WB when memory is zero-wait. With N wait cycles, the instruction reaches MEM/WB after N+1 cycles.
- With DMEM_TIMEOUT=T and no ready, the stall lasts exactly T cycles and MEM/WB loads the abandoned result on the cycle after the last stall cycle.
- dmem_ready arriving in the same cycle as the timeout: ready wins, the access completes normally and there is no fault.
- dmem_ready while dmem_req=0 is ignored.
- Reset during WAIT drops dmem_req asynchronously; the memory side must tolerate a withdrawn request.

## Structure
- Shared package `mem_pkg` holds: funct3 size encodings, mem_to_reg encodings (00 ALU, 01 MEM), and the FSM state encoding.
- One natural sub-module, `load_store_align`: combinational store lane/byte-enable generation, load extraction, and misalignment detection. The FSM, wait counter and MEM/WB register live in mem_stage.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, zero-wait → be=1111, wdata=0xDEADBEEF, no stall, MEM/WB reg_write_en=0.
- LB addr 0x103, rdata 0x80FF_0000 with ready after 3 wait cycles → mem_stall high exactly 3 cycles, three MEM/WB bubbles, then dmem_data_out=0xFFFFFF80.
- LHU addr 0x102, rdata 0x8001_1234, zero-wait → dmem_data_out=0x00008001. SH addr 0x102, data 0x0000ABCD → be=1100, wdata=0xABCDABCD.
- LW addr 0x101 → no dmem_req, mem_fault pulse, reg_write_en=0, no stall.
- DMEM_TIMEOUT=4, LW with ready never asserted → 4 stall cycles, mem_fault pulse, dmem_data_out=0, reg_write_en=0. Repeat with ready on the 4th cycle → normal completion, no fault.
- rst_n low mid-WAIT → dmem_req and all outputs 0 immediately; after release, the next load completes normally.
